iter_divider: RTL

//  Multi-cycle radix-2 restoring integer divider for the CPU execute stage (DIV/DIVU).

---
 rtl/iter_divider.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/iter_divider.sv
// iter_divider: multi-cycle radix-2 restoring integer divider (DIV/DIVU).
// Accepts operands over a valid/ready handshake, produces one quotient bit per
// cycle on the operand magnitudes, applies the sign fix-up on the final
// iteration and holds the result until the consumer takes it.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   flush               cancel any in-flight op; block is IDLE next cycle
//   in_valid/in_ready   operand handshake (in_ready high only in IDLE)
//   in_signed           1 = signed DIV, 0 = DIVU
//   in_dividend/divisor operands, sampled only in the accept cycle
//   out_valid/out_ready result handshake
//   out_quot/out_rem    quotient / remainder
//   out_divzero         divisor was zero for this result
module iter_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quot,
  output logic [WIDTH-1:0] out_rem,
  output logic             out_divzero
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd;   // dividend magnitude, shifted left each iteration
  logic [WIDTH-1:0] dsr;   // divisor magnitude
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quot;
  logic             q_neg;
  logic             r_neg;

  logic             accept_c;
  logic             last_c;
  logic             divzero_c;
  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;
  logic [WIDTH:0]   part_c;
  logic [WIDTH:0]   diff_c;
  logic             q_bit_c;
  logic [WIDTH-1:0] rem_iter_c;
  logic [WIDTH-1:0] quot_iter_c;

  // Operand magnitudes and zero-divisor detect for the accept cycle
  always_comb begin
    divzero_c = (in_divisor == '0);
    a_mag_c   = (in_signed && in_dividend[WIDTH-1]) ? (WIDTH'(0) - in_dividend) : in_dividend;
    b_mag_c   = (in_signed && in_divisor[WIDTH-1])  ? (WIDTH'(0) - in_divisor)  : in_divisor;
  end

  // One restoring iteration. The partial remainder keeps the bit shifted out
  // of rem: with divisors above 2^(WIDTH-1) it can exceed WIDTH bits. Since
  // partial < 2*divisor, the (WIDTH+1)-bit difference's MSB is a clean borrow.
  always_comb begin
    part_c      = {rem, dvd[WIDTH-1]};
    diff_c      = part_c - {1'b0, dsr};
    q_bit_c     = ~diff_c[WIDTH];
    rem_iter_c  = q_bit_c ? diff_c[WIDTH-1:0] : part_c[WIDTH-1:0];
    quot_iter_c = {quot[WIDTH-2:0], q_bit_c};
    last_c      = (cnt == CNT_W'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; flush wins over every other transition
  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && !flush) begin
          accept_c   = 1'b1;
          state_next = divzero_c ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_c) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (flush) begin
      state_next = IDLE;
    end
  end

  // Datapath and registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      dvd         <= '0;
      dsr         <= '0;
      rem         <= '0;
      quot        <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_quot    <= '0;
      out_rem     <= '0;
      out_divzero <= 1'b0;
    end else begin
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
      if (accept_c) begin
        dvd         <= a_mag_c;
        dsr         <= b_mag_c;
        rem         <= '0;
        quot        <= '0;
        cnt         <= '0;
        q_neg       <= in_signed & (in_dividend[WIDTH-1] ^ in_divisor[WIDTH-1]);
        r_neg       <= in_signed & in_dividend[WIDTH-1];
        out_divzero <= divzero_c;
        // Divide by zero skips CALC: result is all-ones / raw dividend
        if (divzero_c) begin
          out_quot <= '1;
          out_rem  <= in_dividend;
        end
      end else if (state == CALC && !flush) begin
        dvd  <= {dvd[WIDTH-2:0], 1'b0};
        rem  <= rem_iter_c;
        quot <= quot_iter_c;
        cnt  <= last_c ? '0 : cnt + CNT_W'(1);
        if (last_c) begin
          out_quot <= q_neg ? (WIDTH'(0) - quot_iter_c) : quot_iter_c;
          out_rem  <= r_neg ? (WIDTH'(0) - rem_iter_c)  : rem_iter_c;
        end
      end else if (flush) begin
        cnt <= '0;
      end
    end
  end

endmodule
